somador_sequencial: RTL and testbench

- Parametrised multi-cycle adder/subtractor, the successor to the fixed 2-bit half/full-adder chain.
- Adds or subtracts two WIDTH-bit operands, processing DIGIT bits per clock through a ripple slice of full-adder cells.
- A carry register links the digits from one cycle to the next.
- Sits behind a start/busy/done handshake so the arithmetic datapath can issue one operation and collect sum, carry and overflow flags.

---
 rtl/somador_sequencial.sv | 137 +++++++++++++
 tb/tb_somador_sequencial.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/somador_sequencial.sv
// Multi-cycle adder/subtractor: DIGIT bits per clock through a ripple slice,
// with a carry register linking digits across cycles and a start/busy/done handshake.
module somador_sequencial #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Ci,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Co,
  output logic             Ov
);

  localparam int unsigned STEPS = WIDTH / DIGIT;
  localparam int unsigned CntW  = (STEPS > 1) ? $clog2(STEPS) : 1;

  if (WIDTH < 2) begin : g_bad_width
    $error("WIDTH must be at least 2");
  end
  if (DIGIT == 0 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("DIGIT must divide WIDTH exactly");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic              carry_q, carry_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  s_q, s_d;
  logic              co_q, co_d;
  logic              ov_q, ov_d;

  logic [DIGIT-1:0]  dig;
  logic [DIGIT:0]    c;

  // Ripple of DIGIT full-adder cells over the low digit of the operand registers
  always_comb begin
    dig  = '0;
    c    = '0;
    c[0] = carry_q;
    for (int i = 0; i < int'(DIGIT); i++) begin
      dig[i]  = a_q[i] ^ b_q[i] ^ c[i];
      c[i+1]  = (a_q[i] & b_q[i]) | (c[i] & (a_q[i] ^ b_q[i]));
    end
  end

  // Next-state and datapath updates for the IDLE/RUN/DONE sequence
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    co_d    = co_q;
    ov_d    = ov_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          // Subtraction as A + ~B + ~Ci, so the same adder serves both modes
          a_d     = A;
          b_d     = sub ? ~B : B;
          carry_d = sub ? ~Ci : Ci;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        // New digit enters at the MSB end; the first digit reaches bit 0 after STEPS shifts
        res_d   = (res_q >> DIGIT) | (WIDTH'(dig) << (WIDTH - DIGIT));
        carry_d = c[DIGIT];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CntW'(STEPS - 1)) begin
          // Last digit: c[DIGIT-1] is the carry into bit WIDTH-1
          s_d     = res_d;
          co_d    = c[DIGIT];
          ov_d    = c[DIGIT-1] ^ c[DIGIT];
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      co_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      co_q    <= co_d;
      ov_q    <= ov_d;
    end
  end

  // Handshake flags decoded from state; results straight from their registers
  always_comb begin
    busy = (state_q != StIdle);
    done = (state_q == StDone);
    S    = s_q;
    Co   = co_q;
    Ov   = ov_q;
  end

endmodule

// File: tb/tb_somador_sequencial.sv
// Bench for somador_sequencial: directed table on the 8/2 build, handshake and
// reset sequences, and a random sweep of the 8/1, 8/8 and 16/4 builds.
module tb_somador_sequencial;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [3:0]  start_v, ci_v, sub_v, busy_v, done_v, co_v, ov_v;
  logic [15:0] a_v [4];
  logic [15:0] b_v [4];
  logic [7:0]  s0, s1, s2;
  logic [15:0] s3;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  somador_sequencial #(.WIDTH(8), .DIGIT(2)) u_d0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .A(a_v[0][7:0]), .B(b_v[0][7:0]),
    .Ci(ci_v[0]), .sub(sub_v[0]), .busy(busy_v[0]), .done(done_v[0]), .S(s0),
    .Co(co_v[0]), .Ov(ov_v[0]));
  somador_sequencial #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .A(a_v[1][7:0]), .B(b_v[1][7:0]),
    .Ci(ci_v[1]), .sub(sub_v[1]), .busy(busy_v[1]), .done(done_v[1]), .S(s1),
    .Co(co_v[1]), .Ov(ov_v[1]));
  somador_sequencial #(.WIDTH(8), .DIGIT(8)) u_d2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .A(a_v[2][7:0]), .B(b_v[2][7:0]),
    .Ci(ci_v[2]), .sub(sub_v[2]), .busy(busy_v[2]), .done(done_v[2]), .S(s2),
    .Co(co_v[2]), .Ov(ov_v[2]));
  somador_sequencial #(.WIDTH(16), .DIGIT(4)) u_d3 (
    .clk(clk), .rst_n(rst_n), .start(start_v[3]), .A(a_v[3]), .B(b_v[3]),
    .Ci(ci_v[3]), .sub(sub_v[3]), .busy(busy_v[3]), .done(done_v[3]), .S(s3),
    .Co(co_v[3]), .Ov(ov_v[3]));

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic       sb;
    logic [7:0] s;
    logic       co;
    logic       ov;
  } vec_t;

  function automatic int w_of(int k);
    return (k == 3) ? 16 : 8;
  endfunction

  function automatic int steps_of(int k);
    case (k)
      0:       return 4;
      1:       return 8;
      2:       return 1;
      default: return 4;
    endcase
  endfunction

  function automatic logic [15:0] s_of(int k);
    case (k)
      0:       return {8'h00, s0};
      1:       return {8'h00, s1};
      2:       return {8'h00, s2};
      default: return s3;
    endcase
  endfunction

  // Reference: {ov, co, s} of a + (sub ? ~b : b) + (sub ? ~ci : ci) at width w
  function automatic logic [17:0] ref_op(int w, logic [15:0] a, logic [15:0] b,
                                         logic ci, logic sb);
    logic [16:0] mask, bb, sum, s;
    logic        cc, co, ov;
    mask = (17'd1 << w) - 17'd1;
    bb   = sb ? (~{1'b0, b}) & mask : {1'b0, b};
    cc   = sb ? ~ci : ci;
    sum  = {1'b0, a} + bb + {16'd0, cc};
    s    = sum & mask;
    co   = sum[w];
    ov   = (a[w-1] == bb[w-1]) && (s[w-1] != a[w-1]);
    return {ov, co, s[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic launch(input int k, input logic [15:0] a, input logic [15:0] b,
                        input logic ci, input logic sb);
    @(negedge clk);
    a_v[k] = a; b_v[k] = b; ci_v[k] = ci; sub_v[k] = sb; start_v[k] = 1'b1;
    @(posedge clk); #1;
    start_v[k] = 1'b0;
  endtask

  // Edges counted after the acceptance edge; -1 on timeout
  task automatic wait_done(input int k, output int lat);
    lat = 0;
    while (!done_v[k] && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!done_v[k]) lat = -1;
  endtask

  task automatic run_op(input int k, input logic [15:0] a, input logic [15:0] b,
                        input logic ci, input logic sb, output logic [15:0] s,
                        output logic co, output logic ov, output int lat);
    launch(k, a, b, ci, sb);
    wait_done(k, lat);
    s  = s_of(k);
    co = co_v[k];
    ov = ov_v[k];
    @(posedge clk); #1;
    chk($sformatf("done_pulse_k%0d", k), {31'd0, done_v[k]}, 32'd0);
  endtask

  initial begin
    vec_t        tbl [8];
    logic [15:0] s, prev_s, msk, ra, rb;
    logic        co, ov, rci, rsb, stable;
    logic [17:0] exp;
    int          lat, n, busy_cnt, done_cnt;

    tbl[0] = '{8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[2] = '{8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[3] = '{8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0};
    tbl[4] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
    tbl[5] = '{8'h05, 8'h03, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0};
    tbl[6] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[7] = '{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0};

    rst_n = 1'b0; start_v = '0; ci_v = '0; sub_v = '0;
    for (int k = 0; k < 4; k++) begin a_v[k] = '0; b_v[k] = '0; end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {28'd0, busy_v}, 32'd0);
    chk("rst_done", {28'd0, done_v}, 32'd0);
    chk("rst_s", {16'd0, s_of(0)}, 32'd0);
    chk("rst_co", {28'd0, co_v}, 32'd0);
    chk("rst_ov", {28'd0, ov_v}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table on the 8/2 build
    for (int i = 0; i < 8; i++) begin
      run_op(0, {8'h00, tbl[i].a}, {8'h00, tbl[i].b}, tbl[i].ci, tbl[i].sb, s, co, ov, lat);
      chk($sformatf("vec%0d_s", i), {16'd0, s}, {24'd0, tbl[i].s});
      chk($sformatf("vec%0d_co", i), {31'd0, co}, {31'd0, tbl[i].co});
      chk($sformatf("vec%0d_ov", i), {31'd0, ov}, {31'd0, tbl[i].ov});
      chk($sformatf("vec%0d_lat", i), lat, 32'd4);
    end

    // Busy spans RUN and DONE: 5 cycles for 8/2, one done pulse
    launch(0, 16'h005A, 16'h003C, 1'b0, 1'b0);
    busy_cnt = 0; done_cnt = 0; n = 0;
    while (busy_v[0] && n < 64) begin
      busy_cnt++;
      if (done_v[0]) done_cnt++;
      @(posedge clk); #1;
      n++;
    end
    chk("busy_cycles", busy_cnt, 32'd5);
    chk("busy_done_count", done_cnt, 32'd1);

    // start held through RUN with new operands: ignored; S stable until done
    @(negedge clk);
    a_v[0] = 16'h0001; b_v[0] = 16'h0002; ci_v[0] = 1'b0; sub_v[0] = 1'b0;
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    a_v[0] = 16'h0010; b_v[0] = 16'h0020;
    prev_s = s_of(0); stable = 1'b1; n = 0;
    while (!done_v[0] && n < 64) begin
      if (s_of(0) !== prev_s) stable = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    start_v[0] = 1'b0;
    chk("hold_s_stable", {31'd0, stable}, 32'd1);
    chk("hold_s", {16'd0, s_of(0)}, 32'h03);
    done_cnt = done_v[0] ? 1 : 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done_v[0]) done_cnt++;
    end
    chk("hold_done_count", done_cnt, 32'd1);
    run_op(0, a_v[0], b_v[0], 1'b0, 1'b0, s, co, ov, lat);
    chk("next_op_s", {16'd0, s}, 32'h30);

    // Reset at step 2 of an operation
    launch(0, 16'h00FF, 16'h0001, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy_v[0]}, 32'd0);
    chk("midrst_done", {31'd0, done_v[0]}, 32'd0);
    chk("midrst_s", {16'd0, s_of(0)}, 32'd0);
    chk("midrst_flags", {30'd0, co_v[0], ov_v[0]}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(0, 16'h0022, 16'h0011, 1'b0, 1'b0, s, co, ov, lat);
    chk("postrst_s", {16'd0, s}, 32'h33);
    chk("postrst_co", {31'd0, co}, 32'd0);
    chk("postrst_lat", lat, 32'd4);

    // Random sweep over the other builds against the reference
    for (int k = 1; k < 4; k++) begin
      msk = (w_of(k) == 16) ? 16'hFFFF : 16'h00FF;
      for (int i = 0; i < 1000; i++) begin
        ra  = 16'($urandom) & msk;
        rb  = 16'($urandom) & msk;
        rci = 1'($urandom);
        rsb = 1'($urandom);
        exp = ref_op(w_of(k), ra, rb, rci, rsb);
        run_op(k, ra, rb, rci, rsb, s, co, ov, lat);
        chk($sformatf("rand_k%0d_%0d_s a=%0h b=%0h ci=%0b sub=%0b", k, i, ra, rb, rci, rsb),
            {16'd0, s}, {16'd0, exp[15:0]});
        chk($sformatf("rand_k%0d_%0d_co_ov", k, i), {30'd0, ov, co}, {30'd0, exp[17:16]});
        chk($sformatf("rand_k%0d_%0d_lat", k, i), lat, steps_of(k));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
